// File: rtl/spi_reg_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl_if
// Groups the SPI pins and the register-access bus of spi_reg_ctrl.
//
// Signals
//   sclk, cs_n, mosi : SPI mode-0 pins from the external master (async to clk)
//   miso             : SPI serial data back to the master
//   wr_rdn           : access direction, 1 = write, 0 = read
//   addr             : register address
//   wdata            : write data
//   we               : access request strobe (both directions)
//   rdata            : read data from the register responder
//   ack, err         : responder completion / error, sampled while we=1
//   err_flag         : sticky error flag
//
// Modports
//   master : the controller side (spi_reg_ctrl)
//   slave  : the SPI master plus register responder side
//
// Handshake: the controller raises we and holds wr_rdn/addr/wdata stable;
// the responder completes the access in the first cycle it drives ack=1
// while we=1 (err qualifies that same cycle, rdata is valid there for reads).
// we drops the cycle after ack is seen.
// ---------------------------------------------------------------------------
interface spi_reg_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int REG_W  = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              wr_rdn;
  logic [ADDR_W-1:0] addr;
  logic [REG_W-1:0]  wdata;
  logic              we;
  logic [REG_W-1:0]  rdata;
  logic              ack;
  logic              err;
  logic              err_flag;

  modport master (
    input  sclk, cs_n, mosi, rdata, ack, err,
    output miso, wr_rdn, addr, wdata, we, err_flag
  );

  modport slave (
    output sclk, cs_n, mosi, rdata, ack, err,
    input  miso, wr_rdn, addr, wdata, we, err_flag
  );
endinterface

// File: rtl/spi_reg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_reg_ctrl
// SPI mode-0 slave that turns a frame {wr_rdn, addr[ADDR_W], data[REG_W]}
// (MSB first) into a single register read or write request.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   ena     : block enable; low holds the block in IDLE with reset outputs
//   bus_if  : spi_reg_ctrl_if.master (SPI pins + register bus)
//   state_o : current FSM state for observation
// ---------------------------------------------------------------------------
module spi_reg_ctrl #(
  parameter int ADDR_W = 7,
  parameter int REG_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  spi_reg_ctrl_if.master       bus_if,
  output logic [2:0]           state_o
);

  localparam int CNT_W = $clog2(((ADDR_W + 1) > REG_W ? (ADDR_W + 1) : REG_W) + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR    = 3'd1,
    RD_REQ = 3'd2,
    DATA   = 3'd3,
    WR_REQ = 3'd4,
    DONE   = 3'd5
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizers. Stage 1 is the metastability flop, stage 2 is the
  // usable value, stage 3 only exists to detect edges of stage 2.
  // cs_n stages reset low: if cs_n is still low when reset releases, no
  // falling edge is seen, so a half-received frame cannot restart mid-way.
  // -------------------------------------------------------------------------
  logic [2:0] sclk_sync_q;
  logic [2:0] cs_sync_q;
  logic [1:0] mosi_sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], bus_if.sclk};
      cs_sync_q   <= {cs_sync_q[1:0], bus_if.cs_n};
      mosi_sync_q <= {mosi_sync_q[0], bus_if.mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign mosi_s    = mosi_sync_q[1];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] hdr_q, hdr_d;
  logic [REG_W-1:0]  sh_q, sh_d;
  logic              wr_rdn_q, wr_rdn_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [REG_W-1:0]  wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              miso_q, miso_d;
  logic              err_flag_q, err_flag_d;

  // Header shift including the bit arriving on this rise; its MSB is wr_rdn.
  logic [ADDR_W:0]   hdr_next;
  logic [REG_W-1:0]  sh_next;
  logic [REG_W-1:0]  rd_load;

  assign hdr_next = {hdr_q, mosi_s};
  assign sh_next  = {sh_q[REG_W-2:0], mosi_s};
  // A responder error returns zeros rather than whatever rdata carries.
  assign rd_load  = bus_if.err ? '0 : bus_if.rdata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hdr_d      = hdr_q;
    sh_d       = sh_q;
    wr_rdn_d   = wr_rdn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    miso_d     = miso_q;
    err_flag_d = err_flag_q;

    if (cs_fall) begin
      err_flag_d = 1'b0;
    end

    if (cs_rise) begin
      // End of frame in any state: a write is only issued from a complete
      // frame, so an incomplete frame simply returns to IDLE. A write still
      // waiting for ack is aborted and flagged.
      state_d = IDLE;
      we_d    = 1'b0;
      miso_d  = 1'b0;
      cnt_d   = '0;
      if (state_q == WR_REQ && (!bus_if.ack || bus_if.err)) begin
        err_flag_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          we_d   = 1'b0;
          miso_d = 1'b0;
          if (cs_fall) begin
            state_d = HDR;
            cnt_d   = '0;
            hdr_d   = '0;
          end
        end

        HDR: begin
          if (sclk_rise) begin
            hdr_d = hdr_next[ADDR_W-1:0];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == HDR_LAST) begin
              cnt_d    = '0;
              wr_rdn_d = hdr_next[ADDR_W];
              addr_d   = hdr_next[ADDR_W-1:0];
              if (hdr_next[ADDR_W]) begin
                state_d = DATA;
                sh_d    = '0;
              end else begin
                state_d = RD_REQ;
                we_d    = 1'b1;
              end
            end
          end
        end

        RD_REQ: begin
          if (we_q && bus_if.ack) begin
            we_d    = 1'b0;
            sh_d    = rd_load;
            state_d = DATA;
            if (bus_if.err) begin
              err_flag_d = 1'b1;
            end
            // The first data fall can coincide with ack; present bit MSB now
            // so the master does not miss it.
            if (sclk_fall) begin
              miso_d = rd_load[REG_W-1];
            end
          end else if (sclk_fall) begin
            // Responder too slow: the master is already clocking data out.
            we_d       = 1'b0;
            sh_d       = '0;
            miso_d     = 1'b0;
            err_flag_d = 1'b1;
            state_d    = DATA;
          end
        end

        DATA: begin
          if (sclk_fall) begin
            miso_d = sh_q[REG_W-1];
          end
          if (sclk_rise) begin
            sh_d  = sh_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DATA_LAST) begin
              cnt_d = '0;
              if (wr_rdn_q) begin
                state_d = WR_REQ;
                we_d    = 1'b1;
                wdata_d = sh_next;
              end else begin
                state_d = DONE;
                miso_d  = 1'b0;
              end
            end
          end
        end

        WR_REQ: begin
          if (we_q && bus_if.ack) begin
            we_d    = 1'b0;
            state_d = DONE;
            if (bus_if.err) begin
              err_flag_d = 1'b1;
            end
          end
        end

        DONE: begin
          we_d   = 1'b0;
          miso_d = 1'b0;
        end

        default: begin
          state_d = IDLE;
          we_d    = 1'b0;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hdr_q      <= '0;
      sh_q       <= '0;
      wr_rdn_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      miso_q     <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      sh_q       <= sh_d;
      wr_rdn_q   <= wr_rdn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      miso_q     <= miso_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign bus_if.miso     = miso_q;
  assign bus_if.wr_rdn   = wr_rdn_q;
  assign bus_if.addr     = addr_q;
  assign bus_if.wdata    = wdata_q;
  assign bus_if.we       = we_q;
  assign bus_if.err_flag = err_flag_q;
  assign state_o         = state_q;

endmodule
